// File: rtl/cache_arb_pkg.sv
// Shared types and constants for the cache/main-memory arbiter.
package cache_arb_pkg;

  localparam int unsigned ADDR_W          = 16;
  localparam int unsigned TIMEOUT_CYC_DEF = 64;
  localparam int unsigned CNT_W_DEF       = 7;

  // Arbiter state encoding (2 bits).
  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    GRANT_I = 2'b01,
    GRANT_D = 2'b10,
    TURN    = 2'b11
  } arb_state_e;

  // Owner encodings presented on the owner port.
  localparam logic [1:0] OWN_NONE = 2'b00;
  localparam logic [1:0] OWN_I    = 2'b01;
  localparam logic [1:0] OWN_D    = 2'b10;

  // Owner code implied by a state; only grant states have an owner.
  function automatic logic [1:0] owner_of(arb_state_e s);
    case (s)
      GRANT_I: return OWN_I;
      GRANT_D: return OWN_D;
      default: return OWN_NONE;
    endcase
  endfunction

endpackage

// File: rtl/arb_watchdog.sv
// Saturating grant-hold counter; flags expiry on the last allowed grant cycle.
module arb_watchdog #(
  parameter int unsigned TIMEOUT_CYC = 64,
  parameter int unsigned CNT_W       = 7
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

  logic [CNT_W-1:0] r_cnt;

  // Count grant cycles; clear has priority, never wrap past all-ones.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (clr) begin
      r_cnt <= '0;
    end else if (en && (r_cnt != CNT_MAX)) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  assign expired = en && (r_cnt >= CNT_LAST);

endmodule

// File: rtl/cache_mem_arbiter.sv
// Arbitrates the main-memory port between the I-cache and D-cache fill
// controllers. A grant is held for a whole fill, followed by one TURN bubble.
// Build option: define ARB_RR_EN for round-robin tie breaking; otherwise the
// D-cache always wins ties.
module cache_mem_arbiter
  import cache_arb_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYC = TIMEOUT_CYC_DEF,
  parameter int unsigned CNT_W       = CNT_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_req,
  input  logic              i_mem_en,
  input  logic [ADDR_W-1:0] i_mem_addr,
  output logic              i_proceed,
  output logic              i_data_valid,
  input  logic              d_req,
  input  logic              d_mem_en,
  input  logic [ADDR_W-1:0] d_mem_addr,
  output logic              d_proceed,
  output logic              d_data_valid,
  output logic              mem_en,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_data_valid,
  output logic [1:0]        owner,
  output logic              timeout_err
);

  arb_state_e r_state;
  logic       r_timeout;
  logic       w_granted;
  logic       w_expired;
  logic       w_any_req;
  logic       w_pick_d;

  assign w_any_req = i_req || d_req;
  assign w_granted = (r_state == GRANT_I) || (r_state == GRANT_D);

`ifdef ARB_RR_EN
  logic r_last_d;

  // Tie goes to whichever side was not served last.
  assign w_pick_d = d_req && (!i_req || !r_last_d);

  // Remember who was granted; starts as "last served I" so D wins first tie.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_last_d <= 1'b0;
    end else if ((r_state == IDLE) && w_any_req) begin
      r_last_d <= w_pick_d;
    end
  end
`else
  // Fixed priority: D-cache wins any tie.
  assign w_pick_d = d_req;
`endif

  // Watchdog runs only while a grant is held and is held clear elsewhere.
  arb_watchdog #(
    .TIMEOUT_CYC (TIMEOUT_CYC),
    .CNT_W       (CNT_W)
  ) u_watchdog (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (!w_granted),
    .en      (w_granted),
    .expired (w_expired)
  );

  // Arbiter FSM; the timeout flag is raised only for the TURN cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_timeout <= 1'b0;
    end else begin
      r_timeout <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_any_req) begin
            r_state <= w_pick_d ? GRANT_D : GRANT_I;
          end
        end
        GRANT_I: begin
          if (!i_req || w_expired) begin
            r_state   <= TURN;
            r_timeout <= w_expired;
          end
        end
        GRANT_D: begin
          if (!d_req || w_expired) begin
            r_state   <= TURN;
            r_timeout <= w_expired;
          end
        end
        TURN: begin
          r_state <= IDLE;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  // Grant and owner decode purely from the state register.
  assign i_proceed   = (r_state == GRANT_I);
  assign d_proceed   = (r_state == GRANT_D);
  assign owner       = owner_of(r_state);
  assign timeout_err = r_timeout;

  // Return memory valid to the owner only; dropped in TURN and IDLE.
  assign i_data_valid = (r_state == GRANT_I) && mem_data_valid;
  assign d_data_valid = (r_state == GRANT_D) && mem_data_valid;

  // Steer the owner's enable/address to memory; park at zero otherwise.
  always_comb begin
    mem_en   = 1'b0;
    mem_addr = '0;
    case (r_state)
      GRANT_I: begin
        mem_en   = i_mem_en;
        mem_addr = i_mem_addr;
      end
      GRANT_D: begin
        mem_en   = d_mem_en;
        mem_addr = d_mem_addr;
      end
      default: begin
        mem_en   = 1'b0;
        mem_addr = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// Bench for cache_mem_arbiter: directed scenarios plus randomized traffic
// compared against a grant/cool-down reference model.
module tb_cache_mem_arbiter;

  localparam int unsigned TMO = 16;
`ifdef ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        i_req = 1'b0;
  logic        i_mem_en = 1'b0;
  logic [15:0] i_mem_addr = 16'h0;
  logic        i_proceed;
  logic        i_data_valid;
  logic        d_req = 1'b0;
  logic        d_mem_en = 1'b0;
  logic [15:0] d_mem_addr = 16'h0;
  logic        d_proceed;
  logic        d_data_valid;
  logic        mem_en;
  logic [15:0] mem_addr;
  logic        mem_data_valid = 1'b0;
  logic [1:0]  owner;
  logic        timeout_err;

  int total = 0;
  int bad   = 0;

  cache_mem_arbiter #(
    .TIMEOUT_CYC (TMO),
    .CNT_W       (7)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .i_req          (i_req),
    .i_mem_en       (i_mem_en),
    .i_mem_addr     (i_mem_addr),
    .i_proceed      (i_proceed),
    .i_data_valid   (i_data_valid),
    .d_req          (d_req),
    .d_mem_en       (d_mem_en),
    .d_mem_addr     (d_mem_addr),
    .d_proceed      (d_proceed),
    .d_data_valid   (d_data_valid),
    .mem_en         (mem_en),
    .mem_addr       (mem_addr),
    .mem_data_valid (mem_data_valid),
    .owner          (owner),
    .timeout_err    (timeout_err)
  );

  always #5 clk = ~clk;

  // Reference model: who holds the port, how long it has held it, and
  // whether the mandatory two-cycle gap after a release is still running.
  int m_cur  = 0;   // 0 none, 1 I, 2 D
  int m_held = 0;
  int m_gap  = 0;
  bit m_last_d = 1'b0;
  bit m_tmo  = 1'b0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_cur = 0; m_held = 0; m_gap = 0; m_last_d = 1'b0; m_tmo = 1'b0;
    end else begin
      m_tmo = 1'b0;
      if (m_cur != 0) begin
        m_held = m_held + 1;
        if (!(m_cur == 1 ? i_req : d_req) || m_held == int'(TMO)) begin
          m_tmo = (m_held == int'(TMO));
          m_cur = 0;
          m_gap = 1;
        end
      end else if (m_gap > 0) begin
        m_gap = m_gap - 1;
      end else if (i_req || d_req) begin
        if (i_req && d_req) m_cur = (RR && m_last_d) ? 1 : 2;
        else                m_cur = i_req ? 1 : 2;
        m_last_d = (m_cur == 2);
        m_held = 0;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    i_req = 1'b0; d_req = 1'b0; i_mem_en = 1'b0; d_mem_en = 1'b0;
    i_mem_addr = 16'h0; d_mem_addr = 16'h0; mem_data_valid = 1'b0;
    rst_n = 1'b0;
    step(); step();
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_reset();
    i_mem_en = 1'b1; i_mem_addr = 16'hBEEF; d_mem_en = 1'b1; d_mem_addr = 16'h5555;
    mem_data_valid = 1'b1;
    #1 rst_n = 1'b0;
    #1;
    total++; if (owner !== 2'b00) begin bad++; $display("FAIL reset_owner: got %b want 00", owner); end
    total++; if (mem_en !== 1'b0) begin bad++; $display("FAIL reset_mem_en: got %b want 0", mem_en); end
    total++; if (mem_addr !== 16'h0000) begin bad++; $display("FAIL reset_mem_addr: got %h want 0000", mem_addr); end
    total++; if ({i_proceed, d_proceed} !== 2'b00) begin bad++; $display("FAIL reset_proceed: got %b want 00", {i_proceed, d_proceed}); end
    total++; if ({i_data_valid, d_data_valid, timeout_err} !== 3'b000) begin bad++; $display("FAIL reset_valid_tmo: got %b want 000", {i_data_valid, d_data_valid, timeout_err}); end
    apply_reset();
  endtask

  task automatic test_d_fill();
    int n_d;
    int n_i;
    apply_reset();
    for (int c = 0; c < 5; c++) step();
    d_req = 1'b1;
    @(negedge clk);
    total++; if (d_proceed !== 1'b0) begin bad++; $display("FAIL dfill_latency: got d_proceed=%b want 0", d_proceed); end
    step();
    total++; if (d_proceed !== 1'b1 || owner !== 2'b10) begin bad++; $display("FAIL dfill_grant: got proceed=%b owner=%b want 1/10", d_proceed, owner); end
    n_d = 0; n_i = 0;
    for (int w = 0; w < 8; w++) begin
      logic [15:0] exp_addr;
      exp_addr = 16'h1230 + 16'(2 * w);
      d_mem_en = 1'b1; d_mem_addr = exp_addr;
      i_mem_en = 1'b1; i_mem_addr = 16'hFFFF;
      mem_data_valid = 1'b1;
      @(negedge clk);
      total++; if (mem_en !== 1'b1 || mem_addr !== exp_addr) begin bad++; $display("FAIL dfill_addr: got en=%b addr=%h want 1/%h", mem_en, mem_addr, exp_addr); end
      if (d_data_valid === 1'b1) n_d++;
      if (i_data_valid === 1'b1) n_i++;
      step();
    end
    total++; if (n_d != 8 || n_i != 0) begin bad++; $display("FAIL dfill_pulses: got d=%0d i=%0d want 8/0", n_d, n_i); end
    d_req = 1'b0; mem_data_valid = 1'b0;
    step();
    total++; if (d_proceed !== 1'b0 || owner !== 2'b00 || mem_addr !== 16'h0000 || mem_en !== 1'b0) begin bad++; $display("FAIL dfill_turn: got proceed=%b owner=%b en=%b addr=%h want 0/00/0/0000", d_proceed, owner, mem_en, mem_addr); end
    step();
    total++; if (owner !== 2'b00) begin bad++; $display("FAIL dfill_idle: got owner=%b want 00", owner); end
    i_mem_en = 1'b0; d_mem_en = 1'b0;
  endtask

  task automatic test_tie();
    logic [1:0] exp_own;
    apply_reset();
    i_req = 1'b1; d_req = 1'b1;
    for (int r = 0; r < 3; r++) begin
      step();
      exp_own = (RR && r == 1) ? 2'b01 : 2'b10;
      total++; if (owner !== exp_own) begin bad++; $display("FAIL tie_round%0d: got owner=%b want %b", r, owner, exp_own); end
      step();
      if (exp_own == 2'b10) d_req = 1'b0; else i_req = 1'b0;
      step();
      total++; if (owner !== 2'b00) begin bad++; $display("FAIL tie_turn%0d: got owner=%b want 00", r, owner); end
      i_req = 1'b1; d_req = 1'b1;
      step();
      total++; if (owner !== 2'b00) begin bad++; $display("FAIL tie_idle%0d: got owner=%b want 00", r, owner); end
    end
    i_req = 1'b0; d_req = 1'b0;
    step(); step(); step();
  endtask

  task automatic test_mid_fill();
    apply_reset();
    i_req = 1'b1; i_mem_en = 1'b1;
    step();
    total++; if (i_proceed !== 1'b1) begin bad++; $display("FAIL mid_i_grant: got %b want 1", i_proceed); end
    d_req = 1'b1;
    for (int k = 0; k < 4; k++) begin
      step();
      total++; if (d_proceed !== 1'b0 || i_proceed !== 1'b1) begin bad++; $display("FAIL mid_hold%0d: got i=%b d=%b want 1/0", k, i_proceed, d_proceed); end
    end
    i_req = 1'b0;
    step();
    mem_data_valid = 1'b1;
    @(negedge clk);
    total++; if ({i_data_valid, d_data_valid, d_proceed, mem_en} !== 4'b0000) begin bad++; $display("FAIL mid_turn: got idv/ddv/dp/en=%b want 0000", {i_data_valid, d_data_valid, d_proceed, mem_en}); end
    step();
    total++; if ({i_data_valid, d_data_valid, d_proceed} !== 3'b000) begin bad++; $display("FAIL mid_idle: got idv/ddv/dp=%b want 000", {i_data_valid, d_data_valid, d_proceed}); end
    step();
    total++; if (d_proceed !== 1'b1 || d_data_valid !== 1'b1) begin bad++; $display("FAIL mid_regrant: got dp=%b ddv=%b want 1/1", d_proceed, d_data_valid); end
    d_req = 1'b0; mem_data_valid = 1'b0; i_mem_en = 1'b0;
    step(); step(); step();
  endtask

  task automatic test_timeout();
    int n;
    int pulses;
    apply_reset();
    i_req = 1'b1;
    step();
    n = 0; pulses = 0;
    for (int k = 0; k < 40 && i_proceed === 1'b1; k++) begin
      n++;
      if (timeout_err === 1'b1) pulses++;
      step();
    end
    total++; if (n != int'(TMO)) begin bad++; $display("FAIL tmo_len: got %0d grant cycles want %0d", n, TMO); end
    total++; if (timeout_err !== 1'b1 || i_proceed !== 1'b0) begin bad++; $display("FAIL tmo_pulse: got err=%b proceed=%b want 1/0", timeout_err, i_proceed); end
    step();
    if (timeout_err === 1'b1) pulses++;
    total++; if (pulses != 0 || i_proceed !== 1'b0) begin bad++; $display("FAIL tmo_single: got extra=%0d proceed=%b want 0/0", pulses, i_proceed); end
    step();
    total++; if (i_proceed !== 1'b1 || timeout_err !== 1'b0) begin bad++; $display("FAIL tmo_regrant: got proceed=%b err=%b want 1/0", i_proceed, timeout_err); end
    i_req = 1'b0;
    step(); step(); step();
  endtask

  task automatic test_reset_mid_grant();
    apply_reset();
    d_req = 1'b1; d_mem_en = 1'b1; d_mem_addr = 16'hA5A4; mem_data_valid = 1'b1;
    step();
    total++; if (d_proceed !== 1'b1 || mem_addr !== 16'hA5A4) begin bad++; $display("FAIL rstg_grant: got dp=%b addr=%h want 1/a5a4", d_proceed, mem_addr); end
    #2 rst_n = 1'b0;
    #1;
    total++; if ({d_proceed, owner, mem_en, d_data_valid} !== 5'b00000 || mem_addr !== 16'h0000) begin bad++; $display("FAIL rstg_async: got dp/own/en/ddv=%b addr=%h want 00000/0000", {d_proceed, owner, mem_en, d_data_valid}, mem_addr); end
    d_req = 1'b0;
    step();
    rst_n = 1'b1;
    step();
    total++; if (owner !== 2'b00) begin bad++; $display("FAIL rstg_idle: got owner=%b want 00", owner); end
    d_req = 1'b1;
    step();
    total++; if (d_proceed !== 1'b1) begin bad++; $display("FAIL rstg_regrant: got dp=%b want 1", d_proceed); end
    d_req = 1'b0; d_mem_en = 1'b0; mem_data_valid = 1'b0;
    step(); step(); step();
  endtask

  task automatic test_random();
    logic [1:0]  e_own;
    logic        e_en;
    logic [15:0] e_addr;
    apply_reset();
    for (int k = 0; k < 800; k++) begin
      step();
      if ($urandom_range(11) == 0) i_req = ~i_req;
      if ($urandom_range(11) == 0) d_req = ~d_req;
      i_mem_en = 1'($urandom); d_mem_en = 1'($urandom);
      i_mem_addr = 16'($urandom); d_mem_addr = 16'($urandom);
      mem_data_valid = 1'($urandom);
      @(negedge clk);
      e_own  = 2'(m_cur);
      e_en   = (m_cur == 1) ? i_mem_en : (m_cur == 2) ? d_mem_en : 1'b0;
      e_addr = (m_cur == 1) ? i_mem_addr : (m_cur == 2) ? d_mem_addr : 16'h0000;
      total++; if (owner !== e_own) begin bad++; $display("FAIL rnd_owner@%0d: got %b want %b", k, owner, e_own); end
      total++; if ({i_proceed, d_proceed} !== {m_cur == 1, m_cur == 2}) begin bad++; $display("FAIL rnd_proceed@%0d: got %b want %b", k, {i_proceed, d_proceed}, {m_cur == 1, m_cur == 2}); end
      total++; if (mem_en !== e_en || mem_addr !== e_addr) begin bad++; $display("FAIL rnd_mem@%0d: got %b/%h want %b/%h", k, mem_en, mem_addr, e_en, e_addr); end
      total++; if ({i_data_valid, d_data_valid} !== {mem_data_valid && m_cur == 1, mem_data_valid && m_cur == 2}) begin bad++; $display("FAIL rnd_dv@%0d: got %b", k, {i_data_valid, d_data_valid}); end
      total++; if (timeout_err !== m_tmo) begin bad++; $display("FAIL rnd_tmo@%0d: got %b want %b", k, timeout_err, m_tmo); end
    end
    i_req = 1'b0; d_req = 1'b0;
    step(); step(); step();
  endtask

  initial begin
    test_reset();
    test_d_fill();
    test_tie();
    test_mid_fill();
    test_timeout();
    test_reset_mid_grant();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
